kbest_frame_sequencer: RTL

- Frame-level controller for the 4x4 16-QAM K-best detector chain: the path generator followed by NSTAGE-1 detector stages.
- Loads one frame (8x8 real-valued R, 8-entry Y) from a word stream into holding registers and drives them onto the chain.
- Sequences per-stage enables through the pipeline latency.
- Raises a result handshake when the last stage's PATH/PED outputs are valid; the next frame is accepted only after the result is consumed.

---
 rtl/kbest_frame_sequencer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/kbest_frame_sequencer.sv
// Frame controller for the 16-QAM K-best chain: loads 72 R/Y words, walks the stage enables,
// then holds the result handshake. Define FRAME_CNT_EN for frame_cnt/ovr_err status outputs.
module kbest_frame_sequencer #(
  parameter int unsigned WL        = 16,
  parameter int unsigned NSTAGE    = 4,
  parameter int unsigned STAGE_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [WL-1:0]     in_data,
  output logic              in_ready,
  output logic [64*WL-1:0]  R_flat,
  output logic [8*WL-1:0]   Y_flat,
  output logic              det_start,
  output logic [NSTAGE-1:0] stage_en,
  output logic              det_busy,
  output logic              res_valid,
  input  logic              res_ready
`ifdef FRAME_CNT_EN
  ,
  output logic [15:0]       frame_cnt,
  output logic [0:0]        ovr_err
`endif
);

  localparam int unsigned RunLen   = NSTAGE * STAGE_LAT;
  localparam int unsigned CntW     = $clog2(RunLen + 1);
  localparam int unsigned NumWords = 72;

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [6:0]      widx_q, widx_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [WL-1:0]   r_q [64];
  logic [WL-1:0]   y_q [8];
  logic            wr_en;

  always_comb begin
    state_d   = state_q;
    widx_d    = widx_q;
    cnt_d     = '0;
    in_ready  = 1'b0;
    det_start = 1'b0;
    stage_en  = '0;
    det_busy  = 1'b0;
    res_valid = 1'b0;
    wr_en     = 1'b0;
    unique case (state_q)
      StIdle: state_d = StLoad;
      StLoad: begin
        in_ready = 1'b1;
        if (in_valid) begin
          wr_en = 1'b1;
          if (widx_q == 7'(NumWords - 1)) begin
            widx_d  = '0;
            state_d = StRun;
          end else begin
            widx_d = widx_q + 7'd1;
          end
        end
      end
      StRun: begin
        det_busy  = 1'b1;
        det_start = (cnt_q == '0);
        // Stage k owns the window [k*STAGE_LAT, (k+1)*STAGE_LAT) of the run counter.
        for (int k = 0; k < NSTAGE; k++) begin
          stage_en[k] = (32'(cnt_q) >= k * STAGE_LAT) && (32'(cnt_q) < (k + 1) * STAGE_LAT);
        end
        if (32'(cnt_q) == RunLen - 1) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        det_busy  = 1'b1;
        res_valid = 1'b1;
        if (res_ready) begin
          state_d = StLoad;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      widx_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      widx_q  <= widx_d;
      cnt_q   <= cnt_d;
    end
  end

  // Holding registers only change on accepted words, so RUN/DONE always see a frozen frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) r_q[i] <= '0;
      for (int i = 0; i < 8; i++) y_q[i] <= '0;
    end else if (wr_en) begin
      if (widx_q < 7'd64) begin
        r_q[widx_q[5:0]] <= in_data;
      end else begin
        y_q[widx_q[2:0]] <= in_data;
      end
    end
  end

  always_comb begin
    R_flat = '0;
    Y_flat = '0;
    for (int i = 0; i < 64; i++) R_flat[i*WL +: WL] = r_q[i];
    for (int i = 0; i < 8; i++) Y_flat[i*WL +: WL] = y_q[i];
  end

`ifdef FRAME_CNT_EN
  logic [15:0] frame_cnt_q;
  logic        ovr_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= '0;
      ovr_err_q   <= 1'b0;
    end else begin
      if (res_valid && res_ready) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (state_q == StDone && in_valid) ovr_err_q <= 1'b1;
    end
  end

  assign frame_cnt  = frame_cnt_q;
  assign ovr_err[0] = ovr_err_q;
`endif

endmodule
